controller: RTL and testbench

- Mode-selectable LED sequencer.
- A 2-bit switch input selects off, or one of three prescaler rates derived from the system clock SCLK.
- Each prescaler tick advances a single-lit running light on 16 LEDs and toggles a divided-clock output, mode_clock.
- Sits between board switches/LEDs and the system clock; purely synchronous apart from reset.

---
 rtl/controller.sv | 133 +++++++++++++
 tb/tb_controller.sv | 120 ++++++++++++
 2 files changed

// File: rtl/controller.sv
// LED running-light sequencer: SW picks off or one of three prescaler rates; each tick
// advances a single lit LED and toggles mode_clock. Define PINGPONG_EN for a bouncing light.
module controller #(
   parameter int DIV1 = 1000,
   parameter int DIV2 = 500,
   parameter int DIV3 = 200
) (
   input  logic        SCLK,
   input  logic        RST,
   input  logic [1:0]  SW,
   output logic [15:0] LD,
   output logic        mode_clock
);

   localparam int DIV_MAX = (DIV1 > DIV2) ? ((DIV1 > DIV3) ? DIV1 : DIV3)
                                          : ((DIV2 > DIV3) ? DIV2 : DIV3);
   localparam int CNT_W = $clog2(DIV_MAX);

   localparam logic [CNT_W-1:0] LAST1 = CNT_W'(DIV1 - 1);
   localparam logic [CNT_W-1:0] LAST2 = CNT_W'(DIV2 - 1);
   localparam logic [CNT_W-1:0] LAST3 = CNT_W'(DIV3 - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      ld_q, ld_d;
   logic             mc_q, mc_d;
   logic [1:0]       sw_q, sw_d;
   logic [CNT_W-1:0] n_last;
   logic [15:0]      ld_adv;

`ifdef PINGPONG_EN
   logic dir_right_q, dir_right_d;
   logic dir_adv;
`endif

   always_comb begin
      case (SW)
         2'd1:    n_last = LAST1;
         2'd2:    n_last = LAST2;
         default: n_last = LAST3;
      endcase
   end

   // Pattern the LEDs take on the next tick.
`ifdef PINGPONG_EN
   always_comb begin
      ld_adv  = ld_q;
      dir_adv = dir_right_q;
      if (!dir_right_q) begin
         if (ld_q[15]) begin
            ld_adv  = ld_q >> 1;
            dir_adv = 1'b1;
         end else begin
            ld_adv = ld_q << 1;
         end
      end else begin
         if (ld_q[0]) begin
            ld_adv  = ld_q << 1;
            dir_adv = 1'b0;
         end else begin
            ld_adv = ld_q >> 1;
         end
      end
   end
`else
   always_comb begin
      ld_adv = {ld_q[14:0], ld_q[15]};
   end
`endif

   always_comb begin
      cnt_d = cnt_q;
      ld_d  = ld_q;
      mc_d  = mc_q;
      sw_d  = SW;
`ifdef PINGPONG_EN
      dir_right_d = dir_right_q;
`endif
      if (SW == 2'd0) begin
         cnt_d = '0;
         mc_d  = 1'b0;
         ld_d  = '0;
`ifdef PINGPONG_EN
         dir_right_d = 1'b0;
`endif
      end else if (ld_q == 16'h0000) begin
         ld_d  = 16'h0001;
         cnt_d = '0;
`ifdef PINGPONG_EN
         dir_right_d = 1'b0;
`endif
      end else if (SW != sw_q) begin
         // Rate change restarts the count so cnt never sits above the new limit.
         cnt_d = '0;
      end else if (cnt_q == n_last) begin
         cnt_d = '0;
         mc_d  = ~mc_q;
         ld_d  = ld_adv;
`ifdef PINGPONG_EN
         dir_right_d = dir_adv;
`endif
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge SCLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
         ld_q  <= '0;
         mc_q  <= 1'b0;
         sw_q  <= 2'd0;
      end else begin
         cnt_q <= cnt_d;
         ld_q  <= ld_d;
         mc_q  <= mc_d;
         sw_q  <= sw_d;
      end
   end

`ifdef PINGPONG_EN
   always_ff @(posedge SCLK or posedge RST) begin
      if (RST) begin
         dir_right_q <= 1'b0;
      end else begin
         dir_right_q <= dir_right_d;
      end
   end
`endif

   assign LD         = ld_q;
   assign mode_clock = mc_q;

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller at default rates: table-driven main flow plus
// hand-written sequences for asynchronous reset and long-run light pattern.
module tb_controller;

   logic        SCLK = 1'b0;
   logic        RST  = 1'b0;
   logic [1:0]  SW   = 2'd1;
   logic [15:0] LD;
   logic        mode_clock;

   int n_tests = 0;
   int n_fail  = 0;

   controller dut (
      .SCLK       (SCLK),
      .RST        (RST),
      .SW         (SW),
      .LD         (LD),
      .mode_clock (mode_clock)
   );

   always #5 SCLK = ~SCLK;

   typedef struct {
      logic        rst;
      logic [1:0]  sw;
      int          adv;
      logic [15:0] ld;
      logic        mc;
      string       name;
   } vec_t;

   vec_t vecs[21];

`ifdef PINGPONG_EN
   localparam logic [15:0] EXP_T16 = 16'h4000;
   localparam logic [15:0] EXP_T30 = 16'h0001;
   localparam logic [15:0] EXP_T31 = 16'h0002;
`else
   localparam logic [15:0] EXP_T16 = 16'h0001;
   localparam logic [15:0] EXP_T30 = 16'h4000;
   localparam logic [15:0] EXP_T31 = 16'h8000;
`endif

   task automatic step(input int n);
      repeat (n) @(posedge SCLK);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] exp_ld, input logic exp_mc);
      n_tests++;
      if (LD !== exp_ld || mode_clock !== exp_mc) begin
         n_fail++;
         $display("FAIL %s: got LD=%h mode_clock=%b, expected LD=%h mode_clock=%b",
                  name, LD, mode_clock, exp_ld, exp_mc);
      end else begin
         $display("ok   %s: LD=%h mode_clock=%b", name, LD, mode_clock);
      end
   endtask

   initial begin
      vecs[0]  = '{1'b1, 2'd1, 3,     16'h0000, 1'b0, "reset"};
      vecs[1]  = '{1'b0, 2'd1, 1,     16'h0001, 1'b0, "load"};
      vecs[2]  = '{1'b0, 2'd1, 999,   16'h0001, 1'b0, "pre_tick1"};
      vecs[3]  = '{1'b0, 2'd1, 1,     16'h0002, 1'b1, "tick1"};
      vecs[4]  = '{1'b0, 2'd1, 14000, 16'h8000, 1'b1, "tick15"};
      vecs[5]  = '{1'b0, 2'd1, 1000,  16'h0001, 1'b0, "wrap_tick16"};
      vecs[6]  = '{1'b0, 2'd1, 16000, 16'h0001, 1'b0, "tick32"};
      vecs[7]  = '{1'b0, 2'd1, 700,   16'h0001, 1'b0, "cnt700"};
      vecs[8]  = '{1'b0, 2'd2, 1,     16'h0001, 1'b0, "rate_1to2"};
      vecs[9]  = '{1'b0, 2'd2, 499,   16'h0001, 1'b0, "rate2_pre"};
      vecs[10] = '{1'b0, 2'd2, 1,     16'h0002, 1'b1, "rate2_tick"};
      vecs[11] = '{1'b0, 2'd3, 1,     16'h0002, 1'b1, "rate_2to3"};
      vecs[12] = '{1'b0, 2'd3, 199,   16'h0002, 1'b1, "rate3_pre"};
      vecs[13] = '{1'b0, 2'd3, 1,     16'h0004, 1'b0, "rate3_tick"};
      vecs[14] = '{1'b0, 2'd3, 200,   16'h0008, 1'b1, "rate3_tick2"};
      vecs[15] = '{1'b0, 2'd3, 200,   16'h0010, 1'b0, "rate3_tick3"};
      vecs[16] = '{1'b0, 2'd0, 1,     16'h0000, 1'b0, "off"};
      vecs[17] = '{1'b0, 2'd0, 2000,  16'h0000, 1'b0, "off_hold"};
      vecs[18] = '{1'b0, 2'd3, 1,     16'h0001, 1'b0, "reenter"};
      vecs[19] = '{1'b0, 2'd3, 199,   16'h0001, 1'b0, "reenter_pre"};
      vecs[20] = '{1'b0, 2'd3, 1,     16'h0002, 1'b1, "reenter_tick"};

      RST = 1'b1;
      #1;
      for (int i = 0; i < 21; i++) begin
         RST = vecs[i].rst;
         SW  = vecs[i].sw;
         step(vecs[i].adv);
         check(vecs[i].name, vecs[i].ld, vecs[i].mc);
      end

      // Asynchronous reset between edges: outputs clear with no SCLK edge.
      step(50);
      #2;
      RST = 1'b1;
      #1;
      check("async_rst", 16'h0000, 1'b0);
      step(3);
      check("rst_hold", 16'h0000, 1'b0);
      RST = 1'b0;
      SW  = 2'd3;
      step(1);
      check("post_rst_load", 16'h0001, 1'b0);

      // Long run at SW=3 across the end of the LED bank.
      step(200 * 15);
      check("sw3_tick15", 16'h8000, 1'b1);
      step(200);
      check("sw3_tick16", EXP_T16, 1'b0);
      step(200 * 14);
      check("sw3_tick30", EXP_T30, 1'b0);
      step(200);
      check("sw3_tick31", EXP_T31, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
